operand_fetch: RTL and testbench

//  Issue stage between decode and execute. Holds one decoded uop and requests its operands

---
 rtl/operand_fetch_pkg.sv | 36 +++
 rtl/operand_fetch_sat_counter.sv | 35 +++
 rtl/operand_fetch.sv | 171 +++++++++++++++++
 tb/tb_operand_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and helpers for the operand-fetch issue stage.
// Register addresses are 6 bits wide; the top bit selects the FP file.
package operand_fetch_pkg;

  localparam int unsigned RegAddrW = 6;

  // Register address: fp=1 selects the floating-point file, idx is the register number.
  typedef struct packed {
    logic       fp;
    logic [4:0] idx;
  } reg_addr_t;

  // The four architectural addresses a uop carries through the fetch slot.
  typedef struct packed {
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rs3;
  } addr_set_t;

  typedef enum logic {
    F_EMPTY   = 1'b0,
    F_PENDING = 1'b1
  } fetch_state_e;

  typedef enum logic {
    E_EMPTY = 1'b0,
    E_FULL  = 1'b1
  } exec_state_e;

  // Operand buses must be wide enough for either register file.
  function automatic int unsigned max_len(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/operand_fetch_sat_counter.sv
// Saturating up-counter used to count hazard stall cycles.
// Holds at all-ones once reached; clears on reset.
module sat_counter
  import operand_fetch_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch issue stage between decode and execute.
// A fetch slot holds one decoded uop and requests its operands (and the rd
// lock) from the register file; on grant the operands, uop and rd are
// captured into the execute pipeline register. One uop/cycle without hazards.
// Optional stall counter: define OPERAND_FETCH_STALL_CNT_EN to add stall_cnt_o.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter  int unsigned XLEN        = 64,
  parameter  int unsigned FLEN        = 32,
  parameter  int unsigned UOP_W       = 32,
  parameter  int unsigned STALL_CNT_W = 32,
  localparam int unsigned MaxLen      = max_len(XLEN, FLEN)
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              flush_i,
  // decode side
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [UOP_W-1:0]  dec_uop_i,
  input  logic [5:0]        dec_rd_addr_i,
  input  logic [5:0]        dec_rs1_addr_i,
  input  logic [5:0]        dec_rs2_addr_i,
  input  logic [5:0]        dec_rs3_addr_i,
  // register file side
  output logic              rf_req_o,
  input  logic              rf_gnt_i,
  output logic [5:0]        rf_rd_addr_o,
  output logic [5:0]        rf_rs1_addr_o,
  output logic [5:0]        rf_rs2_addr_o,
  output logic [5:0]        rf_rs3_addr_o,
  input  logic [MaxLen-1:0] rf_rs1_data_i,
  input  logic [MaxLen-1:0] rf_rs2_data_i,
  input  logic [MaxLen-1:0] rf_rs3_data_i,
  // execute side
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [UOP_W-1:0]  ex_uop_o,
  output logic [5:0]        ex_rd_addr_o,
  output logic [MaxLen-1:0] ex_rs1_data_o,
  output logic [MaxLen-1:0] ex_rs2_data_o,
  output logic [MaxLen-1:0] ex_rs3_data_o
`ifdef OPERAND_FETCH_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  fetch_state_e      f_q, f_d;
  exec_state_e       e_q, e_d;
  addr_set_t         f_addr_q, f_addr_d;
  logic [UOP_W-1:0]  f_uop_q, f_uop_d;
  logic [UOP_W-1:0]  ex_uop_q, ex_uop_d;
  reg_addr_t         ex_rd_q, ex_rd_d;
  logic [MaxLen-1:0] ex_rs1_q, ex_rs1_d;
  logic [MaxLen-1:0] ex_rs2_q, ex_rs2_d;
  logic [MaxLen-1:0] ex_rs3_q, ex_rs3_d;

  logic e_free;
  logic rf_req;
  logic issue;
  logic dec_ready;
  logic load;

  // Handshake decode: request only when execute can capture, since a grant
  // locks rd irrevocably; decode ready sees a same-cycle issue or flush.
  always_comb begin
    e_free    = (e_q == E_EMPTY) | ex_ready_i;
    rf_req    = (f_q == F_PENDING) & e_free & ~flush_i;
    issue     = rf_req & rf_gnt_i;
    dec_ready = (f_q != F_PENDING) | issue | flush_i;
    load      = dec_valid_i & dec_ready;
  end

  // Next state of both slots: fetch loads from decode (winning over issue and
  // flush); execute captures on issue and drains on ex_ready_i. Flush never
  // touches execute because its rd lock has already been granted.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    f_d      = f_q;
    f_addr_d = f_addr_q;
    f_uop_d  = f_uop_q;
    e_d      = e_q;
    ex_uop_d = ex_uop_q;
    ex_rd_d  = ex_rd_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    ex_rs3_d = ex_rs3_q;

    if (load) begin
      f_d          = F_PENDING;
      f_uop_d      = dec_uop_i;
      f_addr_d.rd  = dec_rd_addr_i;
      f_addr_d.rs1 = dec_rs1_addr_i;
      f_addr_d.rs2 = dec_rs2_addr_i;
      f_addr_d.rs3 = dec_rs3_addr_i;
    end else if (issue || flush_i) begin
      f_d = F_EMPTY;
    end

    if (issue) begin
      e_d      = E_FULL;
      ex_uop_d = f_uop_q;
      ex_rd_d  = f_addr_q.rd;
      ex_rs1_d = rf_rs1_data_i;
      ex_rs2_d = rf_rs2_data_i;
      ex_rs3_d = rf_rs3_data_i;
    end else if (ex_ready_i) begin
      e_d = E_EMPTY;
    end
  end

  // State and payload registers for both slots.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    // NOTE: the payload registers are reset too, so the addresses and captured
    // values read back as zero after reset rather than as stale data.
    if (!arst_ni) begin
      f_q      <= F_EMPTY;
      e_q      <= E_EMPTY;
      f_addr_q <= '0;
      f_uop_q  <= '0;
      ex_uop_q <= '0;
      ex_rd_q  <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      ex_rs3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      f_q      <= f_d;
      e_q      <= e_d;
      f_addr_q <= f_addr_d;
      f_uop_q  <= f_uop_d;
      ex_uop_q <= ex_uop_d;
      ex_rd_q  <= ex_rd_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      ex_rs3_q <= ex_rs3_d;
    end
  end

  assign dec_ready_o   = dec_ready;
  assign rf_req_o      = rf_req;
  assign rf_rd_addr_o  = f_addr_q.rd;
  assign rf_rs1_addr_o = f_addr_q.rs1;
  assign rf_rs2_addr_o = f_addr_q.rs2;
  assign rf_rs3_addr_o = f_addr_q.rs3;
  assign ex_valid_o    = (e_q == E_FULL);
  assign ex_uop_o      = ex_uop_q;
  assign ex_rd_addr_o  = ex_rd_q;
  assign ex_rs1_data_o = ex_rs1_q;
  assign ex_rs2_data_o = ex_rs2_q;
  assign ex_rs3_data_o = ex_rs3_q;

`ifdef OPERAND_FETCH_STALL_CNT_EN
  // A stall cycle is a live request that the register file refuses.
  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .inc_i  (rf_req & ~rf_gnt_i),
    .cnt_o  (stall_cnt_o)
  );
`else
  // Counter width only matters when the stall counter is built.
  logic unused_stall_cnt_w;
  assign unused_stall_cnt_w = (STALL_CNT_W != 0);
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a table of single-cycle vectors for
// the basic and back-to-back flow, then hand-written multi-cycle sequences
// for hazards, execute back-pressure, flush and asynchronous reset.
// The register file is modelled as data = tag | address so captured operands
// can be predicted from the addresses alone.
module tb_operand_fetch;

  localparam logic [63:0] K1 = 64'hA100_0000_0000_0000;
  localparam logic [63:0] K2 = 64'hB200_0000_0000_0000;
  localparam logic [63:0] K3 = 64'hC300_0000_0000_0000;

  logic        clk;
  logic        arst_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_uop;
  logic [5:0]  dec_rd, dec_rs1, dec_rs2, dec_rs3;
  logic        rf_req;
  logic        rf_gnt;
  logic [5:0]  rf_rd, rf_rs1, rf_rs2, rf_rs3;
  logic [63:0] rf_rs1_data, rf_rs2_data, rf_rs3_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_uop;
  logic [5:0]  ex_rd;
  logic [63:0] ex_rs1, ex_rs2, ex_rs3;
`ifdef OPERAND_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch dut (
    .clk_i         (clk),
    .arst_ni       (arst_n),
    .flush_i       (flush),
    .dec_valid_i   (dec_valid),
    .dec_ready_o   (dec_ready),
    .dec_uop_i     (dec_uop),
    .dec_rd_addr_i (dec_rd),
    .dec_rs1_addr_i(dec_rs1),
    .dec_rs2_addr_i(dec_rs2),
    .dec_rs3_addr_i(dec_rs3),
    .rf_req_o      (rf_req),
    .rf_gnt_i      (rf_gnt),
    .rf_rd_addr_o  (rf_rd),
    .rf_rs1_addr_o (rf_rs1),
    .rf_rs2_addr_o (rf_rs2),
    .rf_rs3_addr_o (rf_rs3),
    .rf_rs1_data_i (rf_rs1_data),
    .rf_rs2_data_i (rf_rs2_data),
    .rf_rs3_data_i (rf_rs3_data),
    .ex_valid_o    (ex_valid),
    .ex_ready_i    (ex_ready),
    .ex_uop_o      (ex_uop),
    .ex_rd_addr_o  (ex_rd),
    .ex_rs1_data_o (ex_rs1),
    .ex_rs2_data_o (ex_rs2),
    .ex_rs3_data_o (ex_rs3)
`ifdef OPERAND_FETCH_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt)
`endif
  );

  // Register file model.
  assign rf_rs1_data = K1 | {58'd0, rf_rs1};
  assign rf_rs2_data = K2 | {58'd0, rf_rs2};
  assign rf_rs3_data = K3 | {58'd0, rf_rs3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [31:0] uop;
    logic [5:0]  rd, rs1, rs2, rs3;
    logic        gnt, exr;
    logic        e_dec_ready, e_req;
    logic [5:0]  e_rf_rd, e_rf_rs1;
    logic        e_ex_valid;
    logic [31:0] e_ex_uop;
    logic [5:0]  e_ex_rd;
    logic [63:0] e_ex_rs1, e_ex_rs2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and let combinational outputs settle.
  task automatic drive(input logic dv, input logic [31:0] uop,
                       input logic [5:0] rd, input logic [5:0] rs1,
                       input logic [5:0] rs2, input logic [5:0] rs3,
                       input logic gnt, input logic exr, input logic fl);
    dec_valid = dv;
    dec_uop   = uop;
    dec_rd    = rd;
    dec_rs1   = rs1;
    dec_rs2   = rs2;
    dec_rs3   = rs3;
    rf_gnt    = gnt;
    ex_ready  = exr;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // dv uop rd rs1 rs2 rs3 gnt exr | rdy req rf_rd rf_rs1 exv ex_uop ex_rd ex_rs1 ex_rs2
    vecs[0] = '{1'b1, 32'hA000_0000, 6'd5, 6'd3, 6'd4, 6'd6, 1'b1, 1'b1,
                1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 32'h0, 6'd0, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1,
                1'b1, 1'b1, 6'd5, 6'd3, 1'b0, 32'h0, 6'd0, 64'h0, 64'h0};
    vecs[2] = '{1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1,
                1'b1, 1'b0, 6'd5, 6'd3, 1'b1, 32'hA000_0000, 6'd5, K1 | 64'd3, K2 | 64'd4};
    vecs[3] = '{1'b1, 32'hB000_0001, 6'd1, 6'd11, 6'd21, 6'd31, 1'b1, 1'b1,
                1'b1, 1'b0, 6'd5, 6'd3, 1'b0, 32'hA000_0000, 6'd5, K1 | 64'd3, K2 | 64'd4};
    vecs[4] = '{1'b1, 32'hB000_0002, 6'd2, 6'd12, 6'd22, 6'd32, 1'b1, 1'b1,
                1'b1, 1'b1, 6'd1, 6'd11, 1'b0, 32'hA000_0000, 6'd5, K1 | 64'd3, K2 | 64'd4};
    vecs[5] = '{1'b1, 32'hB000_0003, 6'd3, 6'd13, 6'd23, 6'd33, 1'b1, 1'b1,
                1'b1, 1'b1, 6'd2, 6'd12, 1'b1, 32'hB000_0001, 6'd1, K1 | 64'd11, K2 | 64'd21};
    vecs[6] = '{1'b1, 32'hB000_0004, 6'd4, 6'd14, 6'd24, 6'd34, 1'b1, 1'b1,
                1'b1, 1'b1, 6'd3, 6'd13, 1'b1, 32'hB000_0002, 6'd2, K1 | 64'd12, K2 | 64'd22};
    vecs[7] = '{1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1,
                1'b1, 1'b1, 6'd4, 6'd14, 1'b1, 32'hB000_0003, 6'd3, K1 | 64'd13, K2 | 64'd23};
    vecs[8] = '{1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1,
                1'b1, 1'b0, 6'd4, 6'd14, 1'b1, 32'hB000_0004, 6'd4, K1 | 64'd14, K2 | 64'd24};
    vecs[9] = '{1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1,
                1'b1, 1'b0, 6'd4, 6'd14, 1'b0, 32'hB000_0004, 6'd4, K1 | 64'd14, K2 | 64'd24};

    // Reset
    arst_n = 1'b0;
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    #20;
    check("reset ex_valid", {63'd0, ex_valid}, 64'd0);
    check("reset rf_req", {63'd0, rf_req}, 64'd0);
    check("reset dec_ready", {63'd0, dec_ready}, 64'd1);
    check("reset ex_rd", {58'd0, ex_rd}, 64'd0);
`ifdef OPERAND_FETCH_STALL_CNT_EN
    check("reset stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    #3 arst_n = 1'b1;
    tick();

    // Single uop then four back-to-back uops
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].dv, vecs[i].uop, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].rs3,
            vecs[i].gnt, vecs[i].exr, 1'b0);
      check($sformatf("v%0d dec_ready", i), {63'd0, dec_ready}, {63'd0, vecs[i].e_dec_ready});
      check($sformatf("v%0d rf_req", i), {63'd0, rf_req}, {63'd0, vecs[i].e_req});
      check($sformatf("v%0d rf_rd", i), {58'd0, rf_rd}, {58'd0, vecs[i].e_rf_rd});
      check($sformatf("v%0d rf_rs1", i), {58'd0, rf_rs1}, {58'd0, vecs[i].e_rf_rs1});
      check($sformatf("v%0d ex_valid", i), {63'd0, ex_valid}, {63'd0, vecs[i].e_ex_valid});
      check($sformatf("v%0d ex_uop", i), {32'd0, ex_uop}, {32'd0, vecs[i].e_ex_uop});
      check($sformatf("v%0d ex_rd", i), {58'd0, ex_rd}, {58'd0, vecs[i].e_ex_rd});
      check($sformatf("v%0d ex_rs1", i), ex_rs1, vecs[i].e_ex_rs1);
      check($sformatf("v%0d ex_rs2", i), ex_rs2, vecs[i].e_ex_rs2);
      tick();
    end

    // Hazard: rs1=7 locked for three cycles
    drive(1'b1, 32'hC000_0001, 6'd8, 6'd7, 6'd9, 6'd10, 1'b0, 1'b1, 1'b0);
    check("haz accept dec_ready", {63'd0, dec_ready}, 64'd1);
    check("haz accept rf_req", {63'd0, rf_req}, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC000_0001, 6'd8, 6'd7, 6'd9, 6'd10, 1'b0, 1'b1, 1'b0);
      check($sformatf("haz%0d rf_req", i), {63'd0, rf_req}, 64'd1);
      check($sformatf("haz%0d dec_ready", i), {63'd0, dec_ready}, 64'd0);
      check($sformatf("haz%0d rf_rs1", i), {58'd0, rf_rs1}, 64'd7);
      check($sformatf("haz%0d rf_rd", i), {58'd0, rf_rd}, 64'd8);
      check($sformatf("haz%0d rf_rs2", i), {58'd0, rf_rs2}, 64'd9);
      tick();
    end
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
`ifdef OPERAND_FETCH_STALL_CNT_EN
    check("haz stall_cnt", {32'd0, stall_cnt}, 64'd3);
`endif
    check("haz grant rf_req", {63'd0, rf_req}, 64'd1);
    check("haz grant dec_ready", {63'd0, dec_ready}, 64'd1);
    tick();

    // Execute back-pressure: no request while E full and not draining
    drive(1'b1, 32'hD000_0001, 6'd12, 6'd13, 6'd14, 6'd15, 1'b1, 1'b0, 1'b0);
    check("haz ex_valid", {63'd0, ex_valid}, 64'd1);
    check("haz ex_rd", {58'd0, ex_rd}, 64'd8);
    check("haz ex_rs1", ex_rs1, K1 | 64'd7);
    check("haz ex_rs3", ex_rs3, K3 | 64'd10);
    check("bp accept dec_ready", {63'd0, dec_ready}, 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
      check($sformatf("bp%0d rf_req", i), {63'd0, rf_req}, 64'd0);
      check($sformatf("bp%0d dec_ready", i), {63'd0, dec_ready}, 64'd0);
      check($sformatf("bp%0d ex_rd", i), {58'd0, ex_rd}, 64'd8);
      tick();
    end
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    check("bp release rf_req", {63'd0, rf_req}, 64'd1);
    tick();

    // Flush while pending on a hazard
    drive(1'b1, 32'hE000_0001, 6'd20, 6'd21, 6'd22, 6'd23, 1'b0, 1'b1, 1'b0);
    check("bp replace ex_valid", {63'd0, ex_valid}, 64'd1);
    check("bp replace ex_rd", {58'd0, ex_rd}, 64'd12);
    check("bp replace ex_rs1", ex_rs1, K1 | 64'd13);
    check("fl accept dec_ready", {63'd0, dec_ready}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    check("fl hazard rf_req", {63'd0, rf_req}, 64'd1);
    check("fl hazard dec_ready", {63'd0, dec_ready}, 64'd0);
    tick();
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1);
    check("fl rf_req", {63'd0, rf_req}, 64'd0);
    check("fl dec_ready", {63'd0, dec_ready}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    check("post fl rf_req", {63'd0, rf_req}, 64'd0);
    check("post fl ex_valid", {63'd0, ex_valid}, 64'd0);
    check("post fl ex_rd", {58'd0, ex_rd}, 64'd12);
    check("post fl ex_uop", {32'd0, ex_uop}, 64'hD000_0001);
    check("post fl ex_rs1", ex_rs1, K1 | 64'd13);
`ifdef OPERAND_FETCH_STALL_CNT_EN
    check("post fl stall_cnt", {32'd0, stall_cnt}, 64'd4);
`endif
    tick();

    // Load concurrent with flush, then fill both slots and reset
    drive(1'b1, 32'hF000_0001, 6'd30, 6'd31, 6'd32, 6'd33, 1'b0, 1'b0, 1'b1);
    check("fl load dec_ready", {63'd0, dec_ready}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    check("fl load rf_req", {63'd0, rf_req}, 64'd1);
    check("fl load rf_rs1", {58'd0, rf_rs1}, 64'd31);
    tick();
    drive(1'b1, 32'h6000_0001, 6'd40, 6'd41, 6'd42, 6'd43, 1'b0, 1'b0, 1'b0);
    check("full ex_valid", {63'd0, ex_valid}, 64'd1);
    check("full ex_rd", {58'd0, ex_rd}, 64'd30);
    tick();
    drive(1'b0, 32'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    check("full rf_req", {63'd0, rf_req}, 64'd0);
    check("full dec_ready", {63'd0, dec_ready}, 64'd0);
    check("full rf_rs1", {58'd0, rf_rs1}, 64'd41);
    #2 arst_n = 1'b0;
    #1;
    check("arst ex_valid", {63'd0, ex_valid}, 64'd0);
    check("arst rf_req", {63'd0, rf_req}, 64'd0);
    check("arst dec_ready", {63'd0, dec_ready}, 64'd1);
    check("arst ex_rd", {58'd0, ex_rd}, 64'd0);
    check("arst ex_uop", {32'd0, ex_uop}, 64'd0);
    check("arst rf_rs1", {58'd0, rf_rs1}, 64'd0);
`ifdef OPERAND_FETCH_STALL_CNT_EN
    check("arst stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    #2 arst_n = 1'b1;
    tick();
    check("post arst ex_valid", {63'd0, ex_valid}, 64'd0);
    check("post arst dec_ready", {63'd0, dec_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
